// File: rtl/axis_matrix_packet_checker.sv
// AXI-Stream sink that validates header-framed matrix packets and sums payload.
// Define THROTTLE_EN to drive s_axis_tready from an 8-bit LFSR for backpressure.
module axis_matrix_packet_checker #(
    parameter int         MAX_WORDS = 1024,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic        pkt_done,
    output logic        pkt_ok,
    output logic [2:0]  err_code,
    output logic [15:0] pkt_len_words,
    output logic [31:0] pkt_sum,
    output logic [15:0] ok_count,
    output logic [15:0] err_count,
    output logic        busy
);
    typedef enum logic [1:0] {WAIT_HDR, PAYLOAD, DRAIN} state_t;

    localparam logic [2:0]  E_NONE    = 3'd0;
    localparam logic [2:0]  E_BAD_HDR = 3'd1;
    localparam logic [2:0]  E_EARLY   = 3'd2;
    localparam logic [2:0]  E_BAD_LEN = 3'd3;
    localparam logic [2:0]  E_MISSING = 3'd4;
    localparam logic [15:0] MAXW      = 16'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d;
    logic        done_q, ok_q, rdy_q;
    logic [2:0]  code_q;
    logic [15:0] len_q, okc_q, errc_q;
    logic [31:0] psum_q;

    logic        close_d;
    logic [2:0]  code_d;
    logic [15:0] len_d;
    logic [31:0] sum_d;

    logic        beat;
    logic [15:0] hdr_bytes, hdr_words;
    logic        hdr_bad_len;
    logic [31:0] acc_nx;
    logic [15:0] cnt_nx;

    assign beat        = s_axis_tvalid & rdy_q;
    assign hdr_bytes   = s_axis_tdata[15:0];
    assign hdr_words   = {2'b00, hdr_bytes[15:2]};
    assign hdr_bad_len = (hdr_bytes == 16'd0) || (hdr_bytes[1:0] != 2'b00) ||
                         (hdr_words > MAXW);
    assign acc_nx      = acc_q + s_axis_tdata;
    assign cnt_nx      = cnt_q + 16'd1;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        close_d = 1'b0;
        code_d  = E_NONE;
        len_d   = 16'd0;
        sum_d   = 32'd0;
        if (beat) begin
            unique case (state_q)
                WAIT_HDR: begin
                    if (s_axis_tdata[31:24] != 8'hFF) begin
                        close_d = 1'b1;
                        code_d  = E_BAD_HDR;
                        state_d = s_axis_tlast ? WAIT_HDR : DRAIN;
                    end else if (hdr_bad_len) begin
                        close_d = 1'b1;
                        code_d  = E_BAD_LEN;
                        state_d = s_axis_tlast ? WAIT_HDR : DRAIN;
                    end else if (s_axis_tlast) begin
                        close_d = 1'b1;
                        code_d  = E_EARLY;
                    end else begin
                        rem_d   = hdr_words;
                        cnt_d   = 16'd0;
                        acc_d   = 32'd0;
                        state_d = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    acc_d = acc_nx;
                    cnt_d = cnt_nx;
                    rem_d = rem_q - 16'd1;
                    len_d = cnt_nx;
                    sum_d = acc_nx;
                    if (rem_q == 16'd1) begin
                        close_d = 1'b1;
                        code_d  = s_axis_tlast ? E_NONE : E_MISSING;
                        state_d = s_axis_tlast ? WAIT_HDR : DRAIN;
                    end else if (s_axis_tlast) begin
                        close_d = 1'b1;
                        code_d  = E_EARLY;
                        state_d = WAIT_HDR;
                    end
                end
                DRAIN: begin
                    if (s_axis_tlast) state_d = WAIT_HDR;
                end
                default: state_d = WAIT_HDR;
            endcase
        end
    end

`ifdef THROTTLE_EN
    logic [7:0] lfsr_q;
    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= {lfsr_q[6:0],
                              lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT_HDR;
            rem_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            code_q  <= E_NONE;
            len_q   <= '0;
            psum_q  <= '0;
            okc_q   <= '0;
            errc_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            done_q  <= close_d;
`ifdef THROTTLE_EN
            rdy_q   <= lfsr_q[7];
`else
            rdy_q   <= 1'b1;
`endif
            if (close_d) begin
                ok_q   <= (code_d == E_NONE);
                code_q <= code_d;
                len_q  <= len_d;
                psum_q <= sum_d;
                // Counters saturate rather than wrap so a long soak stays readable.
                if (code_d == E_NONE) begin
                    if (okc_q != 16'hFFFF) okc_q <= okc_q + 16'd1;
                end else begin
                    if (errc_q != 16'hFFFF) errc_q <= errc_q + 16'd1;
                end
            end
        end
    end

    assign s_axis_tready = rdy_q;
    assign pkt_done      = done_q;
    assign pkt_ok        = ok_q;
    assign err_code      = code_q;
    assign pkt_len_words = len_q;
    assign pkt_sum       = psum_q;
    assign ok_count      = okc_q;
    assign err_count     = errc_q;
    assign busy          = (state_q != WAIT_HDR);
endmodule
